// File: rtl/uart_rx_pkg.sv
// Shared types and helpers for the configurable UART receiver.
//   state_e      : receiver FSM states
//   PAR_*        : parity_i encodings (2'b11 is reserved and treated as none)
//   MIN_BITS     : smallest supported data width per frame
//   maj3()       : 2-of-3 majority vote used on the three mid-bit samples
package uart_rx_pkg;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_START  = 3'd1,
    ST_DATA   = 3'd2,
    ST_PARITY = 3'd3,
    ST_STOP1  = 3'd4,
    ST_STOP2  = 3'd5,
    ST_DONE   = 3'd6
  } state_e;

  localparam logic [1:0] PAR_NONE = 2'b00;
  localparam logic [1:0] PAR_EVEN = 2'b01;
  localparam logic [1:0] PAR_ODD  = 2'b10;

  localparam int unsigned MIN_BITS = 5;
  localparam int unsigned NBITS_W  = 4;

  // Majority of three samples.
  function automatic logic maj3(input logic a, input logic b, input logic c);
    return (a & b) | (a & c) | (b & c);
  endfunction

endpackage

// File: rtl/uart_baud_tick.sv
// Oversample tick generator: a divisor counter that pulses tick_o once every
// div_i+1 clocks. clr_i holds the counter at zero so the tick phase can be
// aligned to an external event (e.g. a start edge).
//   clk_i, rst_i : clock, async active-low reset
//   clr_i        : synchronous clear, suppresses tick_o
//   div_i        : tick period minus one
//   tick_o       : registered one-clock tick pulse
module uart_baud_tick #(
  parameter int unsigned DIV_W = 16
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             clr_i,
  input  logic [DIV_W-1:0] div_i,
  output logic             tick_o
);

  logic [DIV_W-1:0] cnt_q, cnt_d;
  logic             tick_q, tick_d;

  // Wrap on >= so a divisor lowered mid-count cannot strand the counter.
  always_comb begin
    cnt_d  = cnt_q + DIV_W'(1);
    tick_d = 1'b0;
    if (clr_i) begin
      cnt_d = '0;
    end else if (cnt_q >= div_i) begin
      cnt_d  = '0;
      tick_d = 1'b1;
    end
  end

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      cnt_q  <= '0;
      tick_q <= 1'b0;
    end else begin
      cnt_q  <= cnt_d;
      tick_q <= tick_d;
    end
  end

  assign tick_o = tick_q;

endmodule

// File: rtl/uart_rx_cfg.sv
// Run-time configurable UART receiver with 16x oversampling and 3-sample
// majority vote. Data width (5..DATA_W), parity mode and stop-bit count are
// latched at the start edge of each frame. Received words are presented on a
// valid/ready interface together with parity/framing/break flags.
//   clk_i, rst_i          : clock, async active-low reset
//   en_i                  : receiver enable (0 aborts any frame in progress)
//   baud_i                : oversample tick period minus one
//   nbits_i, parity_i,
//   stop2_i               : frame format (latched per frame)
//   rx_i                  : asynchronous serial line, idle high
//   ready_i               : downstream accepts the held word
//   dout_o, valid_o       : held word, right-justified
//   perr_o, ferr_o, brk_o : error flags for the held word
//   ovr_o                 : one-clock pulse, frame dropped because a word was held
//   busy_o                : receiver not idle
module uart_rx_cfg
  import uart_rx_pkg::*;
#(
  parameter int unsigned DATA_W      = 9,
  parameter int unsigned OVS         = 16,
  parameter int unsigned DIV_W       = 16,
  parameter int unsigned SYNC_STAGES = 2
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              en_i,
  input  logic [DIV_W-1:0]  baud_i,
  input  logic [3:0]        nbits_i,
  input  logic [1:0]        parity_i,
  input  logic              stop2_i,
  input  logic              rx_i,
  input  logic              ready_i,
  output logic [DATA_W-1:0] dout_o,
  output logic              valid_o,
  output logic              perr_o,
  output logic              ferr_o,
  output logic              brk_o,
  output logic              ovr_o,
  output logic              busy_o
);

  localparam int unsigned S_W = $clog2(OVS);
  localparam logic [S_W-1:0] S_PRE = S_W'(OVS/2 - 1);
  localparam logic [S_W-1:0] S_MID = S_W'(OVS/2);
  localparam logic [S_W-1:0] S_DEC = S_W'(OVS/2 + 1);
  localparam logic [S_W-1:0] S_END = S_W'(OVS - 1);
  localparam logic [NBITS_W-1:0] NB_MIN = NBITS_W'(MIN_BITS);
  localparam logic [NBITS_W-1:0] NB_MAX = NBITS_W'(DATA_W);

  state_e state_q, state_d;

  // Synchroniser and edge register, preset to the idle line level.
  logic [SYNC_STAGES-1:0] sync_q;
  logic                   rx_prev_q;
  logic                   rx_s;
  logic                   rx_fall;

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      sync_q    <= '1;
      rx_prev_q <= 1'b1;
    end else begin
      sync_q    <= (sync_q << 1) | SYNC_STAGES'(rx_i);
      rx_prev_q <= rx_s;
    end
  end

  assign rx_s    = sync_q[SYNC_STAGES-1];
  assign rx_fall = rx_prev_q & ~rx_s;

  // Oversample ticks, phase-aligned to the start edge by clearing in IDLE.
  logic tick;
  logic tick_clr;

  assign tick_clr = (state_q == ST_IDLE);

  uart_baud_tick #(
    .DIV_W (DIV_W)
  ) u_baud_tick (
    .clk_i  (clk_i),
    .rst_i  (rst_i),
    .clr_i  (tick_clr),
    .div_i  (baud_i),
    .tick_o (tick)
  );

  // Frame datapath registers.
  logic [S_W-1:0]     s_q, s_d;
  logic [1:0]         samp_q, samp_d;
  logic [NBITS_W-1:0] bit_cnt_q, bit_cnt_d;
  logic [NBITS_W-1:0] nbits_q, nbits_d;
  logic               par_en_q, par_en_d;
  logic               par_odd_q, par_odd_d;
  logic               stop2_q, stop2_d;
  logic [DATA_W-1:0]  shift_q, shift_d;
  logic               any_one_q, any_one_d;
  logic               perr_acc_q, perr_acc_d;
  logic               ferr_acc_q, ferr_acc_d;
  logic               brk_acc_q, brk_acc_d;

  // Output registers.
  logic [DATA_W-1:0]  dout_q, dout_d;
  logic               valid_q, valid_d;
  logic               perr_q, perr_d;
  logic               ferr_q, ferr_d;
  logic               brk_q, brk_d;
  logic               ovr_q, ovr_d;
  logic               busy_q, busy_d;

  // Decode helpers.
  logic               bit_val;
  logic               at_dec;
  logic               at_end;
  logic               last_bit;
  logic               accept;
  logic [NBITS_W-1:0] nbits_clamped;

  assign bit_val  = maj3(samp_q[0], samp_q[1], rx_s);
  assign at_dec   = tick & (s_q == S_DEC);
  assign at_end   = tick & (s_q == S_END);
  assign last_bit = (bit_cnt_q == nbits_q - NBITS_W'(1));
  assign accept   = valid_q & ready_i;

  always_comb begin
    nbits_clamped = nbits_i;
    if (nbits_i < NB_MIN) begin
      nbits_clamped = NB_MIN;
    end else if (nbits_i > NB_MAX) begin
      nbits_clamped = NB_MAX;
    end
  end

  // State register.
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      ST_IDLE: begin
        if (en_i && rx_fall) state_d = ST_START;
      end
      ST_START: begin
        if (at_dec && bit_val) state_d = ST_IDLE;
        else if (at_end)       state_d = ST_DATA;
      end
      ST_DATA: begin
        if (at_end && last_bit) state_d = par_en_q ? ST_PARITY : ST_STOP1;
      end
      ST_PARITY: begin
        if (at_end) state_d = ST_STOP1;
      end
      ST_STOP1: begin
        // Single stop bit finishes at mid-bit to leave resync margin.
        if (at_dec && !stop2_q) state_d = ST_DONE;
        else if (at_end)        state_d = ST_STOP2;
      end
      ST_STOP2: begin
        if (at_dec) state_d = ST_DONE;
      end
      ST_DONE: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
    if (!en_i) state_d = ST_IDLE;
  end

  // Datapath and output next values.
  always_comb begin
    s_d        = s_q;
    samp_d     = samp_q;
    bit_cnt_d  = bit_cnt_q;
    nbits_d    = nbits_q;
    par_en_d   = par_en_q;
    par_odd_d  = par_odd_q;
    stop2_d    = stop2_q;
    shift_d    = shift_q;
    any_one_d  = any_one_q;
    perr_acc_d = perr_acc_q;
    ferr_acc_d = ferr_acc_q;
    brk_acc_d  = brk_acc_q;
    dout_d     = dout_q;
    valid_d    = valid_q;
    perr_d     = perr_q;
    ferr_d     = ferr_q;
    brk_d      = brk_q;
    ovr_d      = 1'b0;
    busy_d     = (state_d != ST_IDLE);

    // Sample index within the current bit.
    if (state_q == ST_IDLE) begin
      s_d = '0;
    end else if (tick) begin
      s_d = (s_q == S_END) ? '0 : s_q + S_W'(1);
    end

    if (tick && (s_q == S_PRE)) samp_d[0] = rx_s;
    if (tick && (s_q == S_MID)) samp_d[1] = rx_s;

    if (accept) valid_d = 1'b0;

    unique case (state_q)
      ST_IDLE: begin
        if (en_i && rx_fall) begin
          nbits_d    = nbits_clamped;
          par_en_d   = (parity_i == PAR_EVEN) || (parity_i == PAR_ODD);
          par_odd_d  = (parity_i == PAR_ODD);
          stop2_d    = stop2_i;
          bit_cnt_d  = '0;
          shift_d    = '0;
          any_one_d  = 1'b0;
          perr_acc_d = 1'b0;
          ferr_acc_d = 1'b0;
          brk_acc_d  = 1'b0;
        end
      end
      ST_DATA: begin
        if (at_dec) begin
          // Shift right and insert at bit nbits-1 so the word ends right-justified.
          shift_d = shift_q >> 1;
          for (int unsigned i = 0; i < DATA_W; i++) begin
            if (NBITS_W'(i) == nbits_q - NBITS_W'(1)) shift_d[i] = bit_val;
          end
          any_one_d = any_one_q | bit_val;
        end
        if (at_end && !last_bit) bit_cnt_d = bit_cnt_q + NBITS_W'(1);
      end
      ST_PARITY: begin
        if (at_dec) begin
          perr_acc_d = (^shift_q) ^ bit_val ^ par_odd_q;
          any_one_d  = any_one_q | bit_val;
        end
      end
      ST_STOP1: begin
        if (at_dec) begin
          ferr_acc_d = ~bit_val;
          brk_acc_d  = ~bit_val & ~any_one_q;
        end
      end
      ST_STOP2: begin
        if (at_dec && !bit_val) ferr_acc_d = 1'b1;
      end
      ST_DONE: begin
        // A word accepted this same clock frees the slot for the new one.
        if (!valid_q || accept) begin
          dout_d  = shift_q;
          perr_d  = perr_acc_q;
          ferr_d  = ferr_acc_q;
          brk_d   = brk_acc_q;
          valid_d = 1'b1;
        end else begin
          ovr_d = 1'b1;
        end
      end
      default: begin
      end
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      s_q        <= '0;
      samp_q     <= '0;
      bit_cnt_q  <= '0;
      nbits_q    <= '0;
      par_en_q   <= 1'b0;
      par_odd_q  <= 1'b0;
      stop2_q    <= 1'b0;
      shift_q    <= '0;
      any_one_q  <= 1'b0;
      perr_acc_q <= 1'b0;
      ferr_acc_q <= 1'b0;
      brk_acc_q  <= 1'b0;
      dout_q     <= '0;
      valid_q    <= 1'b0;
      perr_q     <= 1'b0;
      ferr_q     <= 1'b0;
      brk_q      <= 1'b0;
      ovr_q      <= 1'b0;
      busy_q     <= 1'b0;
    end else begin
      s_q        <= s_d;
      samp_q     <= samp_d;
      bit_cnt_q  <= bit_cnt_d;
      nbits_q    <= nbits_d;
      par_en_q   <= par_en_d;
      par_odd_q  <= par_odd_d;
      stop2_q    <= stop2_d;
      shift_q    <= shift_d;
      any_one_q  <= any_one_d;
      perr_acc_q <= perr_acc_d;
      ferr_acc_q <= ferr_acc_d;
      brk_acc_q  <= brk_acc_d;
      dout_q     <= dout_d;
      valid_q    <= valid_d;
      perr_q     <= perr_d;
      ferr_q     <= ferr_d;
      brk_q      <= brk_d;
      ovr_q      <= ovr_d;
      busy_q     <= busy_d;
    end
  end

  assign dout_o  = dout_q;
  assign valid_o = valid_q;
  assign perr_o  = perr_q;
  assign ferr_o  = ferr_q;
  assign brk_o   = brk_q;
  assign ovr_o   = ovr_q;
  assign busy_o  = busy_q;

endmodule

// File: tb/tb_uart_rx_cfg.sv
// Directed self-checking bench for uart_rx_cfg. Frames are bit-banged on rx_i
// with a per-test bit time; held words are checked as one packed tuple
// {valid, perr, ferr, brk, dout}.
module tb_uart_rx_cfg;

  logic       clk_i = 1'b0;
  logic       rst_i;
  logic       en_i;
  logic [15:0] baud_i;
  logic [3:0] nbits_i;
  logic [1:0] parity_i;
  logic       stop2_i;
  logic       rx_i;
  logic       ready_i;
  logic [8:0] dout_o;
  logic       valid_o, perr_o, ferr_o, brk_o, ovr_o, busy_o;

  int n_tests = 0;
  int n_fail  = 0;
  int bclk    = 64;
  int ovr_cnt = 0;

  uart_rx_cfg dut (
    .clk_i    (clk_i),
    .rst_i    (rst_i),
    .en_i     (en_i),
    .baud_i   (baud_i),
    .nbits_i  (nbits_i),
    .parity_i (parity_i),
    .stop2_i  (stop2_i),
    .rx_i     (rx_i),
    .ready_i  (ready_i),
    .dout_o   (dout_o),
    .valid_o  (valid_o),
    .perr_o   (perr_o),
    .ferr_o   (ferr_o),
    .brk_o    (brk_o),
    .ovr_o    (ovr_o),
    .busy_o   (busy_o)
  );

  always #5 clk_i = ~clk_i;

  always @(negedge clk_i) if (ovr_o === 1'b1) ovr_cnt++;

  initial begin
    #3ms;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  task automatic set_baud(input int b);
    baud_i = 16'(b);
    bclk   = 16 * (b + 1);
  endtask

  // Hold rx_i at lvl for clks clock periods; changes land 1 ns after an edge.
  task automatic line(input logic lvl, input int clks);
    rx_i = lvl;
    repeat (clks) @(posedge clk_i);
    #1;
  endtask

  // pmode: 0 none, 1 even, 2 odd. Ends with two idle bit times.
  task automatic send_frame(input logic [8:0] data, input int nb, input int pmode,
                            input logic pflip, input logic s1, input int nstop,
                            input logic s2, input int bt);
    logic p;
    p = 1'b0;
    line(1'b0, bt);
    for (int i = 0; i < nb; i++) begin
      line(data[i], bt);
      p = p ^ data[i];
    end
    if (pmode != 0) line(p ^ (pmode == 2) ^ pflip, bt);
    line(s1, bt);
    if (nstop == 2) line(s2, bt);
    line(1'b1, 2 * bt);
  endtask

  task automatic pop();
    ready_i = 1'b1;
    @(posedge clk_i);
    #1;
    ready_i = 1'b0;
  endtask

  task automatic test_reset();
    rst_i = 1'b0; en_i = 1'b1; rx_i = 1'b1; ready_i = 1'b0;
    nbits_i = 4'd8; parity_i = 2'b00; stop2_i = 1'b0;
    set_baud(3);
    repeat (3) @(posedge clk_i);
    #1;
    n_tests++;
    if ({valid_o, perr_o, ferr_o, brk_o, ovr_o, busy_o, dout_o} !== 15'h0) begin
      n_fail++;
      $display("FAIL reset_outputs got=%h exp=0", {valid_o, perr_o, ferr_o, brk_o, ovr_o, busy_o, dout_o});
    end
    rst_i = 1'b1;
    repeat (4) @(posedge clk_i);
    #1;
    n_tests++;
    if ({valid_o, busy_o} !== 2'b00) begin
      n_fail++;
      $display("FAIL reset_idle got=%b exp=00", {valid_o, busy_o});
    end
  endtask

  task automatic test_8n1();
    set_baud(26);
    nbits_i = 4'd8; parity_i = 2'b00; stop2_i = 1'b0;
    send_frame(9'h055, 8, 0, 1'b0, 1'b1, 1, 1'b1, bclk);
    n_tests++;
    if ({valid_o, perr_o, ferr_o, brk_o, dout_o} !== {4'b1000, 9'h055}) begin
      n_fail++;
      $display("FAIL 8n1_word got=%h exp=%h", {valid_o, perr_o, ferr_o, brk_o, dout_o}, {4'b1000, 9'h055});
    end
    pop();
    n_tests++;
    if ({valid_o, busy_o} !== 2'b00) begin
      n_fail++;
      $display("FAIL 8n1_pop got=%b exp=00", {valid_o, busy_o});
    end
  endtask

  task automatic test_9bit_odd();
    set_baud(3);
    nbits_i = 4'd9; parity_i = 2'b10;
    send_frame(9'h1A3, 9, 2, 1'b0, 1'b1, 1, 1'b1, bclk);
    n_tests++;
    if ({valid_o, perr_o, ferr_o, brk_o, dout_o} !== {4'b1000, 9'h1A3}) begin
      n_fail++;
      $display("FAIL odd_good got=%h exp=%h", {valid_o, perr_o, ferr_o, brk_o, dout_o}, {4'b1000, 9'h1A3});
    end
    pop();
    send_frame(9'h1A3, 9, 2, 1'b1, 1'b1, 1, 1'b1, bclk);
    n_tests++;
    if ({valid_o, perr_o, ferr_o, brk_o, dout_o} !== {4'b1100, 9'h1A3}) begin
      n_fail++;
      $display("FAIL odd_bad got=%h exp=%h", {valid_o, perr_o, ferr_o, brk_o, dout_o}, {4'b1100, 9'h1A3});
    end
    pop();
    parity_i = 2'b00; nbits_i = 4'd8;
  endtask

  task automatic test_glitch_break();
    set_baud(3);
    line(1'b0, 3 * 4);
    n_tests++;
    if (busy_o !== 1'b1) begin
      n_fail++;
      $display("FAIL glitch_busy got=%b exp=1", busy_o);
    end
    line(1'b1, 2 * bclk);
    n_tests++;
    if ({valid_o, busy_o} !== 2'b00) begin
      n_fail++;
      $display("FAIL glitch_false_start got=%b exp=00", {valid_o, busy_o});
    end
    line(1'b0, 20 * bclk);
    n_tests++;
    if ({valid_o, perr_o, ferr_o, brk_o, dout_o} !== {4'b1011, 9'h000}) begin
      n_fail++;
      $display("FAIL break_word got=%h exp=%h", {valid_o, perr_o, ferr_o, brk_o, dout_o}, {4'b1011, 9'h000});
    end
    pop();
    line(1'b0, 12 * bclk);
    n_tests++;
    if ({valid_o, busy_o} !== 2'b00) begin
      n_fail++;
      $display("FAIL break_no_retrigger got=%b exp=00", {valid_o, busy_o});
    end
    line(1'b1, 2 * bclk);
    send_frame(9'h05A, 8, 0, 1'b0, 1'b1, 1, 1'b1, bclk);
    n_tests++;
    if ({valid_o, perr_o, ferr_o, brk_o, dout_o} !== {4'b1000, 9'h05A}) begin
      n_fail++;
      $display("FAIL after_break got=%h exp=%h", {valid_o, perr_o, ferr_o, brk_o, dout_o}, {4'b1000, 9'h05A});
    end
    pop();
  endtask

  task automatic test_stop2_overrun();
    int ovr0;
    set_baud(3);
    stop2_i = 1'b1;
    send_frame(9'h0A5, 8, 0, 1'b0, 1'b1, 2, 1'b0, bclk);
    n_tests++;
    if ({valid_o, perr_o, ferr_o, brk_o, dout_o} !== {4'b1010, 9'h0A5}) begin
      n_fail++;
      $display("FAIL stop2_ferr got=%h exp=%h", {valid_o, perr_o, ferr_o, brk_o, dout_o}, {4'b1010, 9'h0A5});
    end
    pop();
    stop2_i = 1'b0;
    n_tests++;
    if (ovr_cnt !== 0) begin
      n_fail++;
      $display("FAIL ovr_quiet got=%0d exp=0", ovr_cnt);
    end
    ovr0 = ovr_cnt;
    send_frame(9'h011, 8, 0, 1'b0, 1'b1, 1, 1'b1, bclk);
    send_frame(9'h022, 8, 0, 1'b0, 1'b1, 1, 1'b1, bclk);
    n_tests++;
    if (ovr_cnt - ovr0 !== 1) begin
      n_fail++;
      $display("FAIL ovr_pulse got=%0d exp=1", ovr_cnt - ovr0);
    end
    n_tests++;
    if ({valid_o, dout_o} !== {1'b1, 9'h011}) begin
      n_fail++;
      $display("FAIL ovr_held got=%h exp=%h", {valid_o, dout_o}, {1'b1, 9'h011});
    end
    pop();
  endtask

  task automatic test_boundaries();
    set_baud(3);
    nbits_i = 4'd3;
    send_frame(9'h015, 5, 0, 1'b0, 1'b1, 1, 1'b1, bclk);
    n_tests++;
    if ({valid_o, perr_o, ferr_o, brk_o, dout_o} !== {4'b1000, 9'h015}) begin
      n_fail++;
      $display("FAIL nbits3 got=%h exp=%h", {valid_o, perr_o, ferr_o, brk_o, dout_o}, {4'b1000, 9'h015});
    end
    pop();
    nbits_i = 4'd5;
    send_frame(9'h015, 5, 0, 1'b0, 1'b1, 1, 1'b1, bclk);
    n_tests++;
    if ({valid_o, perr_o, ferr_o, brk_o, dout_o} !== {4'b1000, 9'h015}) begin
      n_fail++;
      $display("FAIL nbits5 got=%h exp=%h", {valid_o, perr_o, ferr_o, brk_o, dout_o}, {4'b1000, 9'h015});
    end
    pop();
    nbits_i = 4'd8;
    set_baud(0);
    send_frame(9'h0C3, 8, 0, 1'b0, 1'b1, 1, 1'b1, bclk);
    n_tests++;
    if ({valid_o, perr_o, ferr_o, brk_o, dout_o} !== {4'b1000, 9'h0C3}) begin
      n_fail++;
      $display("FAIL baud0 got=%h exp=%h", {valid_o, perr_o, ferr_o, brk_o, dout_o}, {4'b1000, 9'h0C3});
    end
    pop();
    set_baud(26);
    send_frame(9'h096, 8, 0, 1'b0, 1'b1, 1, 1'b1, 445);
    n_tests++;
    if ({valid_o, perr_o, ferr_o, brk_o, dout_o} !== {4'b1000, 9'h096}) begin
      n_fail++;
      $display("FAIL baud_slow3pct got=%h exp=%h", {valid_o, perr_o, ferr_o, brk_o, dout_o}, {4'b1000, 9'h096});
    end
    pop();
    send_frame(9'h069, 8, 0, 1'b0, 1'b1, 1, 1'b1, 419);
    n_tests++;
    if ({valid_o, perr_o, ferr_o, brk_o, dout_o} !== {4'b1000, 9'h069}) begin
      n_fail++;
      $display("FAIL baud_fast3pct got=%h exp=%h", {valid_o, perr_o, ferr_o, brk_o, dout_o}, {4'b1000, 9'h069});
    end
    pop();
  endtask

  task automatic test_reset_reconfig();
    set_baud(3);
    send_frame(9'h077, 8, 0, 1'b0, 1'b1, 1, 1'b1, bclk);
    line(1'b0, bclk);
    line(1'b1, 2 * bclk);
    #3;
    rst_i = 1'b0;
    #1;
    n_tests++;
    if ({valid_o, perr_o, ferr_o, brk_o, ovr_o, busy_o, dout_o} !== 15'h0) begin
      n_fail++;
      $display("FAIL async_reset got=%h exp=0", {valid_o, perr_o, ferr_o, brk_o, ovr_o, busy_o, dout_o});
    end
    rx_i = 1'b1;
    repeat (2) @(posedge clk_i);
    #1;
    rst_i = 1'b1;
    line(1'b1, 2 * bclk);
    send_frame(9'h03C, 8, 0, 1'b0, 1'b1, 1, 1'b1, bclk);
    n_tests++;
    if ({valid_o, perr_o, ferr_o, brk_o, dout_o} !== {4'b1000, 9'h03C}) begin
      n_fail++;
      $display("FAIL post_reset got=%h exp=%h", {valid_o, perr_o, ferr_o, brk_o, dout_o}, {4'b1000, 9'h03C});
    end
    pop();
    // Parity mode switched mid-frame must not affect the frame in flight.
    parity_i = 2'b01;
    fork
      send_frame(9'h03C, 8, 1, 1'b0, 1'b1, 1, 1'b1, bclk);
      begin
        repeat (3 * bclk) @(posedge clk_i);
        parity_i = 2'b10;
      end
    join
    n_tests++;
    if ({valid_o, perr_o, ferr_o, brk_o, dout_o} !== {4'b1000, 9'h03C}) begin
      n_fail++;
      $display("FAIL latched_parity got=%h exp=%h", {valid_o, perr_o, ferr_o, brk_o, dout_o}, {4'b1000, 9'h03C});
    end
    pop();
    parity_i = 2'b00;
    // Disable mid-frame: frame discarded, receiver returns idle.
    line(1'b0, bclk);
    line(1'b1, bclk);
    en_i = 1'b0;
    repeat (2) @(posedge clk_i);
    #1;
    n_tests++;
    if (busy_o !== 1'b0) begin
      n_fail++;
      $display("FAIL disable_idle got=%b exp=0", busy_o);
    end
    line(1'b1, 10 * bclk);
    en_i = 1'b1;
    line(1'b1, 2 * bclk);
    n_tests++;
    if ({valid_o, busy_o} !== 2'b00) begin
      n_fail++;
      $display("FAIL disable_discard got=%b exp=00", {valid_o, busy_o});
    end
  endtask

  initial begin
    test_reset();
    test_8n1();
    test_9bit_odd();
    test_glitch_break();
    test_stop2_overrun();
    test_boundaries();
    test_reset_reconfig();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/uart_rx_cfg.md
Name: uart_rx_cfg

Overview:
- Next-generation, run-time configurable serial receiver that replaces the fixed 8-bit, optional-parity RS232 receiver.
- 16x oversampling with 3-sample majority vote; programmable data width, parity mode and stop-bit count.
- Reports parity, framing, break and overrun errors.
- Presents received words on a valid/ready interface to the downstream register file or FIFO.

Parameters:
- DATA_W, 9, maximum data bits per frame (5..9 supported).
- OVS, 16, oversampling ticks per bit; even, at least 8.
- DIV_W, 16, width of the baud divisor.
- SYNC_STAGES, 2, flip-flop stages on rx_i.

Ports:
- clk_i, in, 1, system clock.
- rst_i, in, 1, reset, asynchronous, active-low.
- en_i, in, 1, receiver enable; 0 forces IDLE, no new frames.
- baud_i, in, DIV_W, oversample tick period minus 1 (tick every baud_i+1 clocks).
- nbits_i, in, 4, data bits per frame; values <5 use 5, values >DATA_W use DATA_W.
- parity_i, in, 2, 00 none, 01 even, 10 odd, 11 none (reserved).
- stop2_i, in, 1, 1 = two stop bits checked.
- rx_i, in, 1, asynchronous serial line, idle high.
- ready_i, in, 1, downstream accepts word.
- dout_o, out, DATA_W, received word, LSB-aligned, unused MSBs 0.
- valid_o, out, 1, word available.
- perr_o, out, 1, parity error for held word; qualified by valid_o.
- ferr_o, out, 1, framing error for held word; qualified by valid_o.
- brk_o, out, 1, break detected for held word; qualified by valid_o.
- ovr_o, out, 1, one-clock pulse: frame completed while valid_o high.
- busy_o, out, 1, high in any state except IDLE.

Behaviour:
- Reset (rst_i low, async):
  - All outputs 0.
  - FSM in IDLE.
  - Synchroniser and edge register preset to 1 (line idle).
- Tick generator:
  - Counter runs 0..baud_i and pulses tick when count == baud_i; baud_i=0 gives a tick every clock.
  - Counter clears while in IDLE, so phase is aligned to the start edge.
- Config latch: nbits_i, parity_i and stop2_i are latched on the IDLE->START transition; changes mid-frame do not affect the current frame.
- FSM states: IDLE, START, DATA, PARITY, STOP1, STOP2, DONE.
  - IDLE -> START on a falling edge of synced rx (prev 1, now 0) with en_i=1.
    - A held-low line never retriggers; edge detection is mandatory.
  - Sample index s counts ticks 0..OVS-1 within each bit.
    - Samples are taken at s = OVS/2-1, OVS/2 and OVS/2+1.
    - The bit value is the 2-of-3 majority, decided at s = OVS/2+1.
  - START: majority 1 means false start -> IDLE, no output. Otherwise continue to DATA at the end of the bit (s = OVS-1).
  - DATA: LSB first; shifts the latched nbits bits, then goes to PARITY if parity is enabled, else STOP1.
  - PARITY:
    - Even mode: error if XOR(data, pbit) = 1.
    - Odd mode: error if it equals 0.
  - STOP1: decided at mid-bit, not end of bit, for resync margin. Majority 0 sets ferr. Then STOP2 if stop2 is set, else DONE.
  - STOP2: same decision rule as STOP1; a 0 here also sets ferr.
  - DONE (one clock):
    - If valid_o=0: load dout_o, perr_o, ferr_o and brk_o; set valid_o.
    - If valid_o=1: drop the new frame, pulse ovr_o, keep the held word.
    - Then -> IDLE.
- brk: set when all data bits, the parity bit (if present) and stop bit 1 are all 0. brk implies ferr.
- Latency: valid_o rises 2 clocks after the tick that samples the last stop bit (decide clock + DONE clock).
- Handshake:
  - valid_o falls on the clock where valid_o and ready_i are both 1.
  - If DONE coincides with that accept clock, the new word loads, valid_o stays 1, and no overrun is reported.
- en_i=0 mid-frame: immediate -> IDLE, partial frame discarded. A held valid_o word is kept.
- Width rules:
  - Shift register is DATA_W wide.
  - Received bits are right-justified by shifting in at bit nbits-1; bits above nbits-1 are zero.

Decomposition:
- Package uart_rx_pkg:
  - State enum.
  - Parity-mode localparams PAR_NONE, PAR_EVEN, PAR_ODD.
  - MIN_BITS=5.
  - Majority-of-3 function.
- Sub-module uart_baud_tick: divisor counter with synchronous clear, producing tick. It is reusable by the planned transmitter.
- The synchroniser stays inline.

Test Plan:
- Test 1, 8N1 byte: baud_i=26 (50 MHz, 115200), nbits=8, parity none, send 0x55 then ready_i=1 -> valid_o rises with dout_o=0x055 and all error flags 0.
- Test 2, 9-bit odd parity: nbits=9, parity=10, send 0x1A3 with a correct parity bit -> dout_o=0x1A3, perr_o=0. Repeat with the parity bit flipped -> perr_o=1.
- Test 3, glitch and break:
  - A 3-tick low glitch on an idle line -> false start, busy_o returns to 0, no valid_o.
  - Holding the line low for 2 frame times -> a single word 0x00 with brk_o=1 and ferr_o=1.
  - No second frame until the line returns high and falls again.
- Test 4, two stop bits and overrun:
  - stop2=1, second stop bit driven 0 -> ferr_o=1.
  - With ready_i=0, send 0x11 then 0x22 -> ovr_o pulses once and dout_o remains 0x11.
- Test 5, boundaries:
  - nbits_i=3 and 5 (both give 5 bits), send 0x15 -> dout_o=0x15.
  - baud_i=0 (tick every clock) frame is received correctly.
  - ±3% baud mismatch is received without error.
- Test 6, reset and reconfiguration:
  - Assert rst_i low mid-DATA -> all outputs 0 asynchronously; after release, the next frame is received cleanly.
  - Change parity_i mid-frame -> the current frame is still decoded with the latched mode.
